// File: rtl/cache_pkg.sv
// cache_pkg: shared FSM states, bus size encodings and access-decode helpers
// for the parametrised write-back data cache.
package cache_pkg;

    typedef enum logic [2:0] {IDLE, WB, REFILL, UNC, UNC_DONE} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef struct packed {
        logic [1:0] size;
        logic       legal;
    } wen_info_t;

    function automatic wen_info_t decode_wen(input logic [3:0] wen);
        wen_info_t r;
        r.legal = 1'b1;
        case (wen)
            4'b0000, 4'b1111:                   r.size = SZ_WORD;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: r.size = SZ_BYTE;
            4'b0011, 4'b1100:                   r.size = SZ_HALF;
            default: begin
                r.size  = SZ_WORD;
                r.legal = 1'b0;
            end
        endcase
        return r;
    endfunction

    // kseg1 window: 0xA000_0000 .. 0xBFFF_FFFF
    function automatic logic is_uncached(input logic [31:0] addr);
        return (addr & 32'hE000_0000) == 32'hA000_0000;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array: valid/dirty/tag/data storage of a direct-mapped cache with
// asynchronous read and synchronous byte-enable and metadata writes.
module dcache_array
    import cache_pkg::*;
#(
    parameter int INDEX_W = 7,
    parameter int OFFSET_W = 2,
    localparam int TAG_W = 30 - INDEX_W - OFFSET_W
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [INDEX_W-1:0]  rd_index,
    input  logic [OFFSET_W-1:0] rd_word,
    output logic                rd_valid,
    output logic                rd_dirty,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [31:0]         rd_data,
    input  logic [INDEX_W-1:0]  wr_index,
    input  logic [OFFSET_W-1:0] wr_word,
    input  logic [3:0]          wr_be,
    input  logic [31:0]         wr_data,
    input  logic                meta_we,
    input  logic                meta_dirty,
    input  logic [TAG_W-1:0]    meta_tag
);

    localparam int SETS = 1 << INDEX_W;

    logic [SETS-1:0]  valid;
    logic [SETS-1:0]  dirty;
    logic [TAG_W-1:0] tags [SETS];
    logic [31:0]      data [SETS << OFFSET_W];

    assign rd_valid = valid[rd_index];
    assign rd_dirty = dirty[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = data[{rd_index, rd_word}];

    // Only the state bits are cleared; tags and data become don't-care once invalid.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid <= '0;
            dirty <= '0;
        end else if (meta_we) begin
            valid[wr_index] <= 1'b1;
            dirty[wr_index] <= meta_dirty;
        end
    end

    always_ff @(posedge clk) begin
        if (meta_we)
            tags[wr_index] <= meta_tag;
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (wr_be[b])
                data[{wr_index, wr_word}][8*b +: 8] <= wr_data[8*b +: 8];
    end

endmodule

// File: rtl/dcache_wb_param.sv
// dcache_wb_param: write-back, write-allocate direct-mapped data cache with
// burst eviction/refill and an optional kseg1 uncached bypass.
module dcache_wb_param
    import cache_pkg::*;
#(
    parameter int INDEX_W = 7,
    parameter int OFFSET_W = 2,
    parameter bit UNCACHED_EN = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        d_cache_stall,
    output logic        data_cache_req,
    output logic [31:0] data_cache_addr,
    output logic        data_cache_wr,
    output logic [1:0]  data_cache_size,
    output logic [31:0] data_cache_wdata,
    input  logic [31:0] data_cache_rdata,
    input  logic        data_cache_dok
);

    localparam int LSB_T = INDEX_W + OFFSET_W + 2;
    localparam int TAG_W = 32 - LSB_T;

    state_t              state, state_nx;
    logic [OFFSET_W-1:0] cnt;
    logic [31:0]         unc_rdata;
    logic [TAG_W-1:0]    tag, rd_tag, meta_tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] word, rd_word, wr_word;
    logic                rd_valid, rd_dirty, meta_we, meta_dirty;
    logic                act, unc, hit, last;
    logic [3:0]          wr_be;
    logic [31:0]         rd_data, wr_data;
    wen_info_t           info;

    assign tag   = data_sram_addr[31:LSB_T];
    assign index = data_sram_addr[LSB_T-1:OFFSET_W+2];
    assign word  = data_sram_addr[OFFSET_W+1:2];
    assign info  = decode_wen(data_sram_wen);
    assign act   = data_sram_en && info.legal;
    assign unc   = UNCACHED_EN && is_uncached(data_sram_addr);
    assign hit   = rd_valid && rd_tag == tag;
    assign last  = data_cache_dok && &cnt;
    // During eviction the array is walked by the beat counter instead of the CPU word.
    assign rd_word = state == WB ? cnt : word;

    dcache_array #(
        .INDEX_W (INDEX_W),
        .OFFSET_W(OFFSET_W)
    ) u_array (
        .clk       (clk),
        .resetn    (resetn),
        .rd_index  (index),
        .rd_word   (rd_word),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_index  (index),
        .wr_word   (wr_word),
        .wr_be     (wr_be),
        .wr_data   (wr_data),
        .meta_we   (meta_we),
        .meta_dirty(meta_dirty),
        .meta_tag  (meta_tag)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            unc_rdata <= '0;
        end else begin
            state <= state_nx;
            if ((state == WB || state == REFILL) && data_cache_dok)
                cnt <= cnt + 1'b1;
            if (state == UNC && data_cache_dok)
                unc_rdata <= data_cache_rdata;
        end
    end

    always_comb begin
        state_nx         = state;
        data_sram_rdata  = '0;
        d_cache_stall    = 1'b0;
        data_cache_req   = 1'b0;
        data_cache_addr  = '0;
        data_cache_wr    = 1'b0;
        data_cache_size  = SZ_WORD;
        data_cache_wdata = '0;
        wr_be            = '0;
        wr_word          = word;
        wr_data          = data_sram_wdata;
        meta_we          = 1'b0;
        meta_dirty       = 1'b0;
        meta_tag         = tag;
        case (state)
            IDLE: begin
                if (act && unc) begin
                    d_cache_stall = 1'b1;
                    state_nx      = UNC;
                end else if (act && !hit) begin
                    d_cache_stall = 1'b1;
                    state_nx      = rd_valid && rd_dirty ? WB : REFILL;
                end else if (act) begin
                    data_sram_rdata = rd_data;
                    wr_be           = data_sram_wen;
                    meta_we         = |data_sram_wen;
                    meta_dirty      = 1'b1;
                end
            end
            WB: begin
                d_cache_stall    = 1'b1;
                data_cache_req   = 1'b1;
                data_cache_addr  = {rd_tag, index, cnt, 2'b00};
                data_cache_wr    = 1'b1;
                data_cache_wdata = rd_data;
                state_nx         = last ? REFILL : WB;
            end
            REFILL: begin
                d_cache_stall   = 1'b1;
                data_cache_req  = 1'b1;
                data_cache_addr = {tag, index, cnt, 2'b00};
                wr_word         = cnt;
                wr_data         = data_cache_rdata;
                wr_be           = {4{data_cache_dok}};
                meta_we         = last;
                state_nx        = last ? IDLE : REFILL;
            end
            UNC: begin
                d_cache_stall    = 1'b1;
                data_cache_req   = 1'b1;
                data_cache_addr  = data_sram_addr;
                data_cache_wr    = |data_sram_wen;
                data_cache_size  = info.size;
                data_cache_wdata = data_sram_wdata;
                state_nx         = data_cache_dok ? UNC_DONE : UNC;
            end
            UNC_DONE: begin
                data_sram_rdata = unc_rdata;
                state_nx        = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dcache_wb_param.sv
// tb_dcache_wb_param: directed and random CPU traffic checked against a
// coherent-memory view plus a per-set tag table of the cache.
module tb_dcache_wb_param;

    localparam int INDEX_W = 7;
    localparam int OFFSET_W = 2;
    localparam int L = 1 << OFFSET_W;
    localparam int SETS = 1 << INDEX_W;
    localparam int LINE_SH = OFFSET_W + 2;
    localparam int TAG_SH = INDEX_W + OFFSET_W + 2;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] wdata;
    } beat_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  wen = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata, baddr, bwdata;
    logic [31:0] brdata = '0;
    logic        stall, req, bwr;
    logic        dok = 1'b0;
    logic [1:0]  bsize;

    beat_t       beats[$];
    logic [31:0] bus_mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];
    bit          mv[SETS];
    bit          md[SETS];
    logic [31:0] mt[SETS];
    int          lat = 2;
    int          wait_n = 0;
    int          proto_err = 0;
    bit          prev_pend = 1'b0;
    beat_t       prev_b;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    dcache_wb_param #(
        .INDEX_W    (INDEX_W),
        .OFFSET_W   (OFFSET_W),
        .UNCACHED_EN(1'b1)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_sram_en    (en),
        .data_sram_wen   (wen),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .d_cache_stall   (stall),
        .data_cache_req  (req),
        .data_cache_addr (baddr),
        .data_cache_wr   (bwr),
        .data_cache_size (bsize),
        .data_cache_wdata(bwdata),
        .data_cache_rdata(brdata),
        .data_cache_dok  (dok)
    );

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] bus_rd(input logic [31:0] a);
        logic [31:0] k = a & ~32'h3;
        return bus_mem.exists(k) ? bus_mem[k] : init_word(k);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        logic [31:0] k = a & ~32'h3;
        return ref_mem.exists(k) ? ref_mem[k] : init_word(k);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [3:0] bus_be(input logic [1:0] size, input logic [1:0] lo);
        return size == 2'b10 ? 4'hF : size == 2'b01 ? (lo[1] ? 4'hC : 4'h3) : 4'b0001 << lo;
    endfunction

    // Bus slave: acknowledges each beat `lat` cycles after it is presented,
    // logs completed beats and throws occasional stray acks while idle.
    always @(posedge clk) begin
        beat_t cur;
        #2;
        cur = '{addr: baddr, wr: bwr, size: bsize, wdata: bwdata};
        if (req) begin
            if (prev_pend && prev_b != cur) proto_err++;
            if (wait_n >= lat) begin
                dok = 1'b1;
                brdata = bus_rd(baddr);
                if (bwr) bus_mem[baddr & ~32'h3] = merge(bus_rd(baddr), bwdata, bus_be(bsize, baddr[1:0]));
                beats.push_back(cur);
                wait_n = 0;
                prev_pend = 1'b0;
            end else begin
                dok = 1'b0;
                wait_n++;
                prev_pend = 1'b1;
                prev_b = cur;
            end
        end else begin
            if (prev_pend && resetn) proto_err++;
            prev_pend = 1'b0;
            wait_n = 0;
            dok = $urandom_range(0, 7) == 0;
            brdata = $urandom;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            mv[s] = 1'b0;
            md[s] = 1'b0;
        end
        ref_mem = bus_mem;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        resetn = 1'b0;
        en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", 32'(req), 32'd0);
        check("rst_addr", baddr, 32'd0);
        check("rst_wr", 32'(bwr), 32'd0);
        check("rst_size", 32'(bsize), 32'd2);
        check("rst_wdata", bwdata, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        model_reset();
    endtask

    // One CPU access: predict class, beats and latency from the model, run it,
    // compare, then fold the access into the model.
    task automatic access(input logic e, input logic [3:0] w, input logic [31:0] a,
                          input logic [31:0] wd, output int sn, output logic [31:0] rd);
        bit          legal;
        logic [1:0]  sz;
        int          set, kind, exp_sn;
        logic [31:0] tg, base, vbase, exp_rd;
        beat_t       exp_q[$];
        legal = w inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
        sz = (w == 4'h0 || w == 4'hF) ? 2'b10 : (w == 4'h3 || w == 4'hC) ? 2'b01 : 2'b00;
        set = int'((a >> LINE_SH) % SETS);
        tg = a >> TAG_SH;
        base = (a >> LINE_SH) << LINE_SH;
        if (!e || !legal) kind = 0;
        else if (a[31:29] == 3'b101) kind = 4;
        else if (mv[set] && mt[set] == tg) kind = 1;
        else kind = (mv[set] && md[set]) ? 3 : 2;
        if (kind == 3) begin
            vbase = (mt[set] << TAG_SH) | (32'(set) << LINE_SH);
            for (int k = 0; k < L; k++)
                exp_q.push_back('{addr: vbase + 32'(4*k), wr: 1'b1, size: 2'b10, wdata: ref_rd(vbase + 32'(4*k))});
        end
        if (kind == 2 || kind == 3)
            for (int k = 0; k < L; k++)
                exp_q.push_back('{addr: base + 32'(4*k), wr: 1'b0, size: 2'b10, wdata: 32'd0});
        if (kind == 4) exp_q.push_back('{addr: a, wr: |w, size: sz, wdata: wd});
        exp_rd = kind == 0 ? 32'd0 : ref_rd(a);
        exp_sn = kind == 2 ? L*(lat+1) + 1 : kind == 3 ? 2*L*(lat+1) + 1 : 0;
        @(posedge clk);
        #1;
        beats.delete();
        en = e;
        wen = w;
        addr = a;
        wdata = wd;
        sn = 0;
        forever begin
            @(negedge clk);
            if (kind <= 1) check("idle_req", 32'(req), 32'd0);
            if (!stall) break;
            sn++;
            if (sn > 2000) begin
                checks++;
                errors++;
                $display("FAIL stall_timeout: got %0d cycles expected at most 2000", sn);
                break;
            end
        end
        rd = rdata;
        if (kind == 0 || w == 4'h0) check("rdata", rdata, exp_rd);
        if (kind != 4) check("stall_cycles", 32'(sn), 32'(exp_sn));
        check("beat_count", 32'(beats.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < beats.size(); k++) begin
            check("beat_addr", beats[k].addr, exp_q[k].addr);
            check("beat_wr", 32'(beats[k].wr), 32'(exp_q[k].wr));
            check("beat_size", 32'(beats[k].size), 32'(exp_q[k].size));
            if (exp_q[k].wr) check("beat_wdata", beats[k].wdata, exp_q[k].wdata);
        end
        if (kind == 2 || kind == 3) begin
            mv[set] = 1'b1;
            md[set] = 1'b0;
            mt[set] = tg;
        end
        if (kind >= 1 && w != 4'h0) begin
            ref_mem[a & ~32'h3] = merge(ref_rd(a), wd, w);
            if (kind <= 3) md[set] = 1'b1;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int sn, n, r;
        logic [31:0] rd, a;
        logic [3:0] w;
        logic [3:0] st_w[7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
        logic [3:0] bad_w[8] = '{4'h5, 4'h6, 4'h9, 4'hA, 4'h7, 4'hB, 4'hD, 4'hE};
        bus_mem[32'h104] = 32'h1122_3344;
        do_reset();

        lat = 2;
        access(1'b1, 4'h0, 32'h0000_0104, 32'h0, sn, rd);
        check("cold_stall", 32'(sn), 32'd13);
        check("cold_rdata", rd, 32'h1122_3344);
        check("cold_beats", 32'(beats.size()), 32'd4);
        for (int k = 0; k < beats.size(); k++)
            check("cold_addr", beats[k].addr, 32'h100 + 32'(4*k));
        access(1'b1, 4'h0, 32'h0000_0108, 32'h0, sn, rd);
        check("rehit_stall", 32'(sn), 32'd0);

        access(1'b1, 4'b0011, 32'h0000_0104, 32'hAAAA_BBBB, sn, rd);
        check("store_beats", 32'(beats.size()), 32'd0);
        access(1'b1, 4'h0, 32'h0000_0104, 32'h0, sn, rd);
        check("store_merge", rd, 32'h1122_BBBB);

        access(1'b1, 4'h0, 32'h0000_0904, 32'h0, sn, rd);
        check("evict_stall", 32'(sn), 32'd25);
        check("evict_beats", 32'(beats.size()), 32'd8);
        if (beats.size() == 8) begin
            check("evict_wr", 32'(beats[1].wr), 32'd1);
            check("evict_merged", beats[1].wdata, 32'h1122_BBBB);
            check("evict_refill", beats[4].addr, 32'h0000_0900);
        end

        access(1'b1, 4'b1000, 32'hA000_0003, 32'hDEAD_BEEF, sn, rd);
        check("unc_beats", 32'(beats.size()), 32'd1);
        if (beats.size() == 1) begin
            check("unc_addr", beats[0].addr, 32'hA000_0003);
            check("unc_size", 32'(beats[0].size), 32'd0);
            check("unc_wr", 32'(beats[0].wr), 32'd1);
        end
        access(1'b1, 4'h0, 32'hA000_0000, 32'h0, sn, rd);
        check("unc_readback", rd[31:24], 32'hDE);

        access(1'b1, 4'b0101, 32'h0000_0904, 32'hFFFF_FFFF, sn, rd);
        check("illegal_stall", 32'(sn), 32'd0);
        access(1'b1, 4'h0, 32'h0000_0904, 32'h0, sn, rd);
        check("illegal_untouched_stall", 32'(sn), 32'd0);

        lat = 2;
        @(posedge clk);
        #1;
        beats.delete();
        en = 1'b1;
        wen = 4'h0;
        addr = 32'h0000_2000;
        n = 0;
        while (beats.size() < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("midrefill_reached", 32'(beats.size()), 32'd2);
        resetn = 1'b0;
        en = 1'b0;
        @(negedge clk);
        check("midrefill_req", 32'(req), 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        model_reset();
        access(1'b1, 4'h0, 32'h0000_2000, 32'h0, sn, rd);
        check("rerefill_stall", 32'(sn), 32'd13);

        for (int i = 0; i < 400; i++) begin
            lat = $urandom_range(0, 3);
            r = $urandom_range(0, 99);
            a = (32'($urandom_range(0, 3)) << TAG_SH) | (32'($urandom_range(0, 3)) << LINE_SH)
                | (32'($urandom_range(0, 3)) << 2);
            if (r < 40) access(1'b1, 4'h0, a, 32'h0, sn, rd);
            else if (r < 75) access(1'b1, st_w[$urandom_range(0, 6)], a, $urandom, sn, rd);
            else if (r < 85) begin
                a = 32'hA000_0000 | (32'($urandom_range(0, 15)) << 2);
                if ($urandom_range(0, 1) == 0) access(1'b1, 4'h0, a, 32'h0, sn, rd);
                else begin
                    w = st_w[$urandom_range(0, 6)];
                    a[1:0] = w == 4'h2 ? 2'd1 : (w == 4'h4 || w == 4'hC) ? 2'd2 : w == 4'h8 ? 2'd3 : 2'd0;
                    access(1'b1, w, a, $urandom, sn, rd);
                end
            end
            else if (r < 92) access(1'b1, bad_w[$urandom_range(0, 7)], a, $urandom, sn, rd);
            else access(1'b0, 4'h0, a, $urandom, sn, rd);
        end

        check("protocol_errors", 32'(proto_err), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
